// File: rtl/order_ref_map.sv
// Direct-mapped order-reference table between the ITCH parser and the order book.
// Adds are stored and forwarded; deletes/executes are looked up and emitted as book decrements.
module order_ref_map #(
    parameter int MAP_DEPTH = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic                 msgValidIn,
    input  logic [1:0]           msgTypeIn,
    input  logic [63:0]          orderRefIn,
    input  logic [15:0]          locateIn,
    input  logic [31:0]          priceIn,
    input  logic [31:0]          sharesIn,
    input  logic                 buySellIn,
    output logic                 addValidOut,
    output logic [15:0]          locateOut,
    output logic [31:0]          priceOut,
    output logic [31:0]          sharesOut,
    output logic                 buySellOut,
    output logic                 delExecValidOut,
    output logic [15:0]          mapLocateOut,
    output logic [31:0]          mapPriceOut,
    output logic [31:0]          mapSharesOut,
    output logic                 mapBuySellOut,
    output logic [CNT_WIDTH-1:0] missCntOut,
    output logic [CNT_WIDTH-1:0] collisionCntOut
);

    localparam int ADDR_BITS = $clog2(MAP_DEPTH);
    localparam int TAG_BITS  = 64 - ADDR_BITS;

    typedef enum logic [1:0] {
        MSG_ADD  = 2'd0,
        MSG_DEL  = 2'd1,
        MSG_EXEC = 2'd2,
        MSG_RSVD = 2'd3
    } msg_type_t;

    typedef struct packed {
        msg_type_t             typ;
        logic [TAG_BITS-1:0]   tag;
        logic [ADDR_BITS-1:0]  idx;
        logic [15:0]           locate;
        logic [31:0]           price;
        logic [31:0]           shares;
        logic                  buy;
    } msg_t;

    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic [15:0]         locate;
        logic [31:0]         price;
        logic [31:0]         rem;
        logic                side;
    } entry_t;

    // Payload RAM carries no reset; liveness is tracked only by r_valid.
    entry_t               r_mem [MAP_DEPTH];
    logic [MAP_DEPTH-1:0] r_valid;

    logic   r_s1_vld;
    msg_t   r_s1_msg;
    logic   r_s2_vld;
    msg_t   r_s2_msg;
    logic   r_s2_ent_valid;
    entry_t r_s2_ent;

    logic   w_fwd;
    logic   w_rd_valid;
    entry_t w_rd_entry;
    logic   w_hit;
    logic [31:0] w_exec;
    logic   w_wr_en;
    logic   w_wb_valid;
    entry_t w_wb_entry;
    logic   w_add_stb;
    logic   w_de_stb;
    logic [31:0] w_map_shares;
    logic   w_miss_inc;
    logic   w_coll_inc;

    // S2 writes back on the same edge S1 advances, so a same-index read in S1 takes S2's result.
    always_comb begin
        w_fwd      = r_s2_vld && w_wr_en && (r_s1_msg.idx == r_s2_msg.idx);
        w_rd_valid = w_fwd ? w_wb_valid : r_valid[r_s1_msg.idx];
        w_rd_entry = w_fwd ? w_wb_entry : r_mem[r_s1_msg.idx];
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_s1_vld       <= 1'b0;
            r_s1_msg       <= '0;
            r_s2_vld       <= 1'b0;
            r_s2_msg       <= '0;
            r_s2_ent_valid <= 1'b0;
            r_s2_ent       <= '0;
        end else begin
            r_s1_vld       <= msgValidIn && (msgTypeIn != MSG_RSVD);
            r_s1_msg.typ   <= msg_type_t'(msgTypeIn);
            r_s1_msg.tag   <= orderRefIn[63:ADDR_BITS];
            r_s1_msg.idx   <= orderRefIn[ADDR_BITS-1:0];
            r_s1_msg.locate <= locateIn;
            r_s1_msg.price <= priceIn;
            r_s1_msg.shares <= sharesIn;
            r_s1_msg.buy   <= buySellIn;
            r_s2_vld       <= r_s1_vld;
            r_s2_msg       <= r_s1_msg;
            r_s2_ent_valid <= w_rd_valid;
            r_s2_ent       <= w_rd_entry;
        end
    end

    always_comb begin
        w_hit        = r_s2_ent_valid && (r_s2_ent.tag == r_s2_msg.tag);
        w_exec       = (r_s2_msg.shares < r_s2_ent.rem) ? r_s2_msg.shares : r_s2_ent.rem;
        w_wr_en      = 1'b0;
        w_wb_valid   = r_s2_ent_valid;
        w_wb_entry   = r_s2_ent;
        w_add_stb    = 1'b0;
        w_de_stb     = 1'b0;
        w_map_shares = r_s2_ent.rem;
        w_miss_inc   = 1'b0;
        w_coll_inc   = 1'b0;
        if (r_s2_vld) begin
            case (r_s2_msg.typ)
                MSG_ADD: begin
                    w_wr_en           = 1'b1;
                    w_wb_valid        = 1'b1;
                    w_wb_entry.tag    = r_s2_msg.tag;
                    w_wb_entry.locate = r_s2_msg.locate;
                    w_wb_entry.price  = r_s2_msg.price;
                    w_wb_entry.rem    = r_s2_msg.shares;
                    w_wb_entry.side   = r_s2_msg.buy;
                    w_add_stb         = 1'b1;
                    w_coll_inc        = r_s2_ent_valid;
                end
                MSG_DEL: begin
                    if (w_hit) begin
                        w_wr_en    = 1'b1;
                        w_wb_valid = 1'b0;
                        w_de_stb   = 1'b1;
                    end else begin
                        w_miss_inc = 1'b1;
                    end
                end
                MSG_EXEC: begin
                    if (w_hit) begin
                        w_wr_en        = 1'b1;
                        w_wb_entry.rem = r_s2_ent.rem - w_exec;
                        w_wb_valid     = (r_s2_ent.rem != w_exec);
                        w_de_stb       = 1'b1;
                        w_map_shares   = w_exec;
                    end else begin
                        w_miss_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkIn) begin
        if (w_wr_en) begin
            r_mem[r_s2_msg.idx] <= w_wb_entry;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[r_s2_msg.idx] <= w_wb_valid;
        end
    end

    // Data outputs only move with their strobe; counters stick at all-ones.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            addValidOut     <= 1'b0;
            locateOut       <= '0;
            priceOut        <= '0;
            sharesOut       <= '0;
            buySellOut      <= 1'b0;
            delExecValidOut <= 1'b0;
            mapLocateOut    <= '0;
            mapPriceOut     <= '0;
            mapSharesOut    <= '0;
            mapBuySellOut   <= 1'b0;
            missCntOut      <= '0;
            collisionCntOut <= '0;
        end else begin
            addValidOut     <= w_add_stb;
            delExecValidOut <= w_de_stb;
            if (w_add_stb) begin
                locateOut  <= r_s2_msg.locate;
                priceOut   <= r_s2_msg.price;
                sharesOut  <= r_s2_msg.shares;
                buySellOut <= r_s2_msg.buy;
            end
            if (w_de_stb) begin
                mapLocateOut  <= r_s2_ent.locate;
                mapPriceOut   <= r_s2_ent.price;
                mapSharesOut  <= w_map_shares;
                mapBuySellOut <= r_s2_ent.side;
            end
            if (w_miss_inc && (missCntOut != '1)) begin
                missCntOut <= missCntOut + CNT_WIDTH'(1);
            end
            if (w_coll_inc && (collisionCntOut != '1)) begin
                collisionCntOut <= collisionCntOut + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_order_ref_map.sv
// Bench for order_ref_map: directed vector table, hand-written pipeline/reset sequences,
// and random traffic scored against a sequential table model.
module tb_order_ref_map;

    logic        clkIn = 1'b0;
    logic        rstIn = 1'b1;
    logic        msgValidIn = 1'b0;
    logic [1:0]  msgTypeIn = '0;
    logic [63:0] orderRefIn = '0;
    logic [15:0] locateIn = '0;
    logic [31:0] priceIn = '0;
    logic [31:0] sharesIn = '0;
    logic        buySellIn = 1'b0;
    logic        addValidOut, buySellOut, delExecValidOut, mapBuySellOut;
    logic [15:0] locateOut, mapLocateOut, missCntOut, collisionCntOut;
    logic [31:0] priceOut, sharesOut, mapPriceOut, mapSharesOut;

    always #5 clkIn = ~clkIn;

    order_ref_map #(.MAP_DEPTH(1024), .CNT_WIDTH(16)) dut (
        .clkIn(clkIn), .rstIn(rstIn), .msgValidIn(msgValidIn), .msgTypeIn(msgTypeIn),
        .orderRefIn(orderRefIn), .locateIn(locateIn), .priceIn(priceIn), .sharesIn(sharesIn),
        .buySellIn(buySellIn), .addValidOut(addValidOut), .locateOut(locateOut),
        .priceOut(priceOut), .sharesOut(sharesOut), .buySellOut(buySellOut),
        .delExecValidOut(delExecValidOut), .mapLocateOut(mapLocateOut),
        .mapPriceOut(mapPriceOut), .mapSharesOut(mapSharesOut), .mapBuySellOut(mapBuySellOut),
        .missCntOut(missCntOut), .collisionCntOut(collisionCntOut)
    );

    typedef struct packed {
        logic        add_v;
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] shares;
        logic        buy;
        logic        dv;
        logic [15:0] mloc;
        logic [31:0] mprice;
        logic [31:0] mshares;
        logic        mbuy;
        logic [15:0] miss;
        logic [15:0] coll;
    } out_t;

    typedef struct {
        logic [1:0]  typ;
        logic [63:0] oref;
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] sh;
        logic        buy;
        logic        e_add;
        logic        e_del;
        logic [15:0] e_loc;
        logic [31:0] e_price;
        logic [31:0] e_sh;
        logic        e_buy;
        logic [15:0] e_miss;
        logic [15:0] e_coll;
    } vec_t;

    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Sequential reference: one slot per index holding the full reference number.
    bit          m_valid [1024];
    logic [63:0] m_ref   [1024];
    logic [15:0] m_loc   [1024];
    logic [31:0] m_price [1024];
    logic [31:0] m_rem   [1024];
    logic        m_side  [1024];
    out_t        m_out;

    function automatic out_t dut_out();
        out_t o;
        o.add_v = addValidOut;      o.loc = locateOut;       o.price = priceOut;
        o.shares = sharesOut;       o.buy = buySellOut;      o.dv = delExecValidOut;
        o.mloc = mapLocateOut;      o.mprice = mapPriceOut;  o.mshares = mapSharesOut;
        o.mbuy = mapBuySellOut;     o.miss = missCntOut;     o.coll = collisionCntOut;
        return o;
    endfunction

    function automatic out_t model(logic v, logic [1:0] t, logic [63:0] r, logic [15:0] l,
                                   logic [31:0] p, logic [31:0] s, logic b);
        out_t o;
        int idx;
        logic [31:0] ex;
        o = m_out;
        o.add_v = 1'b0;
        o.dv = 1'b0;
        idx = int'(r % 64'd1024);
        if (v && t == 2'd0) begin
            if (m_valid[idx] && o.coll != 16'hFFFF) o.coll = o.coll + 16'd1;
            m_valid[idx] = 1'b1; m_ref[idx] = r; m_loc[idx] = l;
            m_price[idx] = p;    m_rem[idx] = s; m_side[idx] = b;
            o.add_v = 1'b1; o.loc = l; o.price = p; o.shares = s; o.buy = b;
        end else if (v && (t == 2'd1 || t == 2'd2)) begin
            if (m_valid[idx] && m_ref[idx] == r) begin
                ex = (t == 2'd1) ? m_rem[idx] : ((s < m_rem[idx]) ? s : m_rem[idx]);
                m_rem[idx] = m_rem[idx] - ex;
                if (m_rem[idx] == 32'd0) m_valid[idx] = 1'b0;
                o.dv = 1'b1; o.mloc = m_loc[idx]; o.mprice = m_price[idx];
                o.mshares = ex; o.mbuy = m_side[idx];
            end else if (o.miss != 16'hFFFF) begin
                o.miss = o.miss + 16'd1;
            end
        end
        m_out = o;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
        m_out = '0;
        exp_q.delete();
    endtask

    task automatic check_out(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge: score the result due now, drive one message, advance.
    task automatic step(input logic v, input logic [1:0] t, input logic [63:0] r,
                        input logic [15:0] l, input logic [31:0] p, input logic [31:0] s,
                        input logic b);
        if (exp_q.size() == 3) check_out("pipe", dut_out(), exp_q.pop_front());
        msgValidIn = v; msgTypeIn = t; orderRefIn = r; locateIn = l;
        priceIn = p;    sharesIn = s;  buySellIn = b;
        exp_q.push_back(model(v, t, r, l, p, s, b));
        @(negedge clkIn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'd0, 64'd0, 16'd0, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic vec_t mk(logic [1:0] typ, logic [63:0] oref, logic [15:0] loc,
                                logic [31:0] price, logic [31:0] sh, logic buy, logic e_add,
                                logic e_del, logic [15:0] e_loc, logic [31:0] e_price,
                                logic [31:0] e_sh, logic e_buy, logic [15:0] e_miss,
                                logic [15:0] e_coll);
        vec_t v;
        v.typ = typ; v.oref = oref; v.loc = loc; v.price = price; v.sh = sh; v.buy = buy;
        v.e_add = e_add; v.e_del = e_del; v.e_loc = e_loc; v.e_price = e_price;
        v.e_sh = e_sh; v.e_buy = e_buy; v.e_miss = e_miss; v.e_coll = e_coll;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(2'd0, 64'h10,  16'd7, 32'd1000, 32'd300, 1'b1, 1, 0, 16'd7, 32'd1000, 32'd300, 1'b1, 16'd0, 16'd0);
        vecs[1]  = mk(2'd1, 64'h10,  16'd0, 32'd0,    32'd0,   1'b0, 0, 1, 16'd7, 32'd1000, 32'd300, 1'b1, 16'd0, 16'd0);
        vecs[2]  = mk(2'd1, 64'h10,  16'd0, 32'd0,    32'd0,   1'b0, 0, 0, 16'd0, 32'd0,    32'd0,   1'b0, 16'd1, 16'd0);
        vecs[3]  = mk(2'd0, 64'h5,   16'd1, 32'd50,   32'd100, 1'b0, 1, 0, 16'd1, 32'd50,   32'd100, 1'b0, 16'd1, 16'd0);
        vecs[4]  = mk(2'd2, 64'h5,   16'd0, 32'd0,    32'd40,  1'b0, 0, 1, 16'd1, 32'd50,   32'd40,  1'b0, 16'd1, 16'd0);
        vecs[5]  = mk(2'd2, 64'h5,   16'd0, 32'd0,    32'd60,  1'b0, 0, 1, 16'd1, 32'd50,   32'd60,  1'b0, 16'd1, 16'd0);
        vecs[6]  = mk(2'd2, 64'h5,   16'd0, 32'd0,    32'd10,  1'b0, 0, 0, 16'd0, 32'd0,    32'd0,   1'b0, 16'd2, 16'd0);
        vecs[7]  = mk(2'd0, 64'h9,   16'd2, 32'd60,   32'd50,  1'b1, 1, 0, 16'd2, 32'd60,   32'd50,  1'b1, 16'd2, 16'd0);
        vecs[8]  = mk(2'd2, 64'h9,   16'd0, 32'd0,    32'd80,  1'b0, 0, 1, 16'd2, 32'd60,   32'd50,  1'b1, 16'd2, 16'd0);
        vecs[9]  = mk(2'd2, 64'h9,   16'd0, 32'd0,    32'd1,   1'b0, 0, 0, 16'd0, 32'd0,    32'd0,   1'b0, 16'd3, 16'd0);
        vecs[10] = mk(2'd0, 64'h001, 16'd3, 32'd70,   32'd10,  1'b0, 1, 0, 16'd3, 32'd70,   32'd10,  1'b0, 16'd3, 16'd0);
        vecs[11] = mk(2'd0, 64'h401, 16'd4, 32'd80,   32'd20,  1'b1, 1, 0, 16'd4, 32'd80,   32'd20,  1'b1, 16'd3, 16'd1);
        vecs[12] = mk(2'd1, 64'h001, 16'd0, 32'd0,    32'd0,   1'b0, 0, 0, 16'd0, 32'd0,    32'd0,   1'b0, 16'd4, 16'd1);
        vecs[13] = mk(2'd1, 64'h401, 16'd0, 32'd0,    32'd0,   1'b0, 0, 1, 16'd4, 32'd80,   32'd20,  1'b1, 16'd4, 16'd1);
        vecs[14] = mk(2'd3, 64'h401, 16'd9, 32'd9,    32'd5,   1'b1, 0, 0, 16'd0, 32'd0,    32'd0,   1'b0, 16'd4, 16'd1);

        // Reset state.
        model_reset();
        repeat (2) @(negedge clkIn);
        check_out("reset_state", dut_out(), '0);
        rstIn = 1'b0;

        // Directed vectors, each isolated by two idle cycles.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].typ, vecs[i].oref, vecs[i].loc, vecs[i].price, vecs[i].sh, vecs[i].buy);
            idle(2);
            check_val("vec_add_valid", 64'(addValidOut), 64'(vecs[i].e_add));
            check_val("vec_del_valid", 64'(delExecValidOut), 64'(vecs[i].e_del));
            if (vecs[i].e_add) begin
                check_val("vec_add_fields", {locateOut, priceOut, sharesOut[14:0], buySellOut},
                          {vecs[i].e_loc, vecs[i].e_price, vecs[i].e_sh[14:0], vecs[i].e_buy});
            end
            if (vecs[i].e_del) begin
                check_val("vec_map_shares", 64'(mapSharesOut), 64'(vecs[i].e_sh));
                check_val("vec_map_fields", {15'd0, mapLocateOut, mapPriceOut, mapBuySellOut},
                          {15'd0, vecs[i].e_loc, vecs[i].e_price, vecs[i].e_buy});
            end
            check_val("vec_miss_cnt", 64'(missCntOut), 64'(vecs[i].e_miss));
            check_val("vec_coll_cnt", 64'(collisionCntOut), 64'(vecs[i].e_coll));
        end

        // Back-to-back same-ref hazard.
        step(1'b1, 2'd0, 64'h3, 16'd11, 32'd77, 32'd200, 1'b1);
        step(1'b1, 2'd2, 64'h3, 16'd0, 32'd0, 32'd50, 1'b0);
        step(1'b1, 2'd2, 64'h3, 16'd0, 32'd0, 32'd50, 1'b0);
        check_val("b2b_add", {addValidOut, delExecValidOut, sharesOut}, {1'b1, 1'b0, 32'd200});
        idle(1);
        check_val("b2b_exec1", {addValidOut, delExecValidOut, mapSharesOut}, {1'b0, 1'b1, 32'd50});
        idle(1);
        check_val("b2b_exec2", {addValidOut, delExecValidOut, mapSharesOut}, {1'b0, 1'b1, 32'd50});
        idle(1);
        step(1'b1, 2'd1, 64'h3, 16'd0, 32'd0, 32'd0, 1'b0);
        idle(2);
        check_val("b2b_delete_rem", {delExecValidOut, mapSharesOut, mapPriceOut}, {1'b1, 32'd100, 32'd77});

        // Async reset with two messages in flight.
        step(1'b1, 2'd0, 64'h77, 16'd5, 32'd500, 32'd30, 1'b0);
        idle(3);
        step(1'b1, 2'd0, 64'h20, 16'd6, 32'd600, 32'd40, 1'b1);
        step(1'b1, 2'd2, 64'h20, 16'd0, 32'd0, 32'd10, 1'b0);
        #2 rstIn = 1'b1;
        msgValidIn = 1'b0;
        #1 check_out("reset_async", dut_out(), '0);
        model_reset();
        repeat (2) @(negedge clkIn);
        rstIn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_val("post_reset_strobe", {addValidOut, delExecValidOut}, 2'b00);
        end
        step(1'b1, 2'd1, 64'h77, 16'd0, 32'd0, 32'd0, 1'b0);
        idle(2);
        check_val("post_reset_miss", {delExecValidOut, missCntOut}, {1'b0, 16'd1});

        // Random traffic over a few indices and tags to provoke hits, collisions and hazards.
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] r;
            logic [31:0] s;
            r = (64'($urandom_range(0, 2)) << 10) | 64'($urandom_range(0, 3));
            s = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 120));
            step($urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)), r,
                 16'($urandom), $urandom, s, 1'($urandom));
        end
        idle(3);

        // Miss counter saturation.
        for (int i = 0; i < 65540; i++) step(1'b1, 2'd1, 64'h3FF, 16'd0, 32'd0, 32'd0, 1'b0);
        idle(3);
        check_val("miss_saturate", 64'(missCntOut), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
